// File: rtl/apb_pkg.sv
// Shared definitions for the APB request arbiter: FSM state encoding,
// default bus widths and the default completion timeout.
package apb_pkg;

    // Default client address width; bit 8 selects slave 2 downstream.
    localparam int APB_ADDR_W = 9;
    // Default client data width.
    localparam int APB_DATA_W = 8;
    // Default number of PENABLE-without-PREADY cycles before a transfer is aborted.
    localparam int APB_TMO    = 15;
    // Width of the timeout counter.
    localparam int TMO_CNT_W  = 4;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. Purely combinational: a sole requester always
// wins; on a tie the client that was not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    // Pick the winner from the request pattern and the last-served pointer.
    always_comb begin
        gnt     = 2'b00;
        gnt_idx = 1'b0;
        case (req)
            2'b01: begin
                gnt     = 2'b01;
                gnt_idx = 1'b0;
            end
            2'b10: begin
                gnt     = 2'b10;
                gnt_idx = 1'b1;
            end
            2'b11: begin
                // Tie: hand the bus to the client that did not go last.
                if (last) begin
                    gnt     = 2'b01;
                    gnt_idx = 1'b0;
                end else begin
                    gnt     = 2'b10;
                    gnt_idx = 1'b1;
                end
            end
            default: begin
                gnt     = 2'b00;
                gnt_idx = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Two-client round-robin arbiter and sequencer in front of apb_master.
// Latches the winning client's command, holds it stable on the master
// command port while transfer is high, watches the APB phase signals for
// completion, error or timeout, then returns a one-cycle done pulse with
// read data and an error flag to the granted client.
module apb_req_arbiter
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W,
    parameter int TMO    = APB_TMO
) (
    input  logic                  PCLK,
    input  logic                  PRST,
    input  logic [1:0]            req,
    input  logic [1:0]            rd_wr,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [2*DATA_W-1:0]   wdata,
    output logic [1:0]            gnt,
    output logic [1:0]            done,
    output logic                  err,
    output logic [DATA_W-1:0]     rdata,
    output logic                  transfer,
    output logic                  RD_WR,
    output logic [ADDR_W-1:0]     apb_rd_padd,
    output logic [ADDR_W-1:0]     apb_wr_padd,
    output logic [DATA_W-1:0]     apb_wr_data,
    input  logic [DATA_W-1:0]     apb_rd_data_out,
    input  logic                  PENABLE,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    // Final timeout count: the abort fires on the edge that would make the
    // count of stalled ENABLE cycles equal TMO.
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TMO - 1);

    arb_state_e                state_reg;
    arb_state_e                state_next;

    logic                      last_reg;
    logic [1:0]                gnt_reg;
    logic                      cmd_rd_wr_reg;
    logic [ADDR_W-1:0]         cmd_addr_reg;
    logic [DATA_W-1:0]         cmd_wdata_reg;
    logic [TMO_CNT_W-1:0]      tmo_cnt_reg;
    logic [DATA_W-1:0]         rdata_reg;
    logic                      err_reg;

    logic [1:0]                arb_gnt;
    logic                      arb_idx;

    logic [ADDR_W-1:0]         cl_addr  [2];
    logic [DATA_W-1:0]         cl_wdata [2];

    logic                      apb_complete;
    logic                      tmo_stall;
    logic                      tmo_hit;

    // Unpack the per-client command buses into indexable arrays.
    for (genvar gi = 0; gi < 2; gi++) begin : g_client
        assign cl_addr[gi]  = addr[gi*ADDR_W +: ADDR_W];
        assign cl_wdata[gi] = wdata[gi*DATA_W +: DATA_W];
    end

    rr_arb2 u_rr_arb2 (
        .req     (req),
        .last    (last_reg),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Completion and timeout qualifiers decoded from the observed APB phase.
    assign apb_complete = PENABLE && PREADY;
    assign tmo_stall    = PENABLE && !PREADY;
    assign tmo_hit      = tmo_stall && (tmo_cnt_reg == TMO_LAST);

    // State register.
    always_ff @(posedge PCLK or negedge PRST) begin
        if (!PRST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode: grant on any request, finish on completion/error/timeout.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (apb_complete || PSLVERR || tmo_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State-decoded outputs: transfer for the whole BUSY stay, done only in DONE.
    always_comb begin
        transfer = 1'b0;
        done     = 2'b00;
        case (state_reg)
            BUSY:    transfer = 1'b1;
            DONE:    done     = gnt_reg;
            default: begin
                transfer = 1'b0;
                done     = 2'b00;
            end
        endcase
    end

    // Grant and command latch: captured once at arbitration so the master
    // sees a stable command even if the client changes its inputs.
    always_ff @(posedge PCLK or negedge PRST) begin
        if (!PRST) begin
            gnt_reg       <= 2'b00;
            last_reg      <= 1'b1;
            cmd_rd_wr_reg <= 1'b0;
            cmd_addr_reg  <= '0;
            cmd_wdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        gnt_reg       <= arb_gnt;
                        cmd_rd_wr_reg <= rd_wr[arb_idx];
                        cmd_addr_reg  <= cl_addr[arb_idx];
                        cmd_wdata_reg <= cl_wdata[arb_idx];
                    end
                end
                DONE: begin
                    last_reg <= gnt_reg[1];
                    gnt_reg  <= 2'b00;
                end
                default: begin
                    gnt_reg <= gnt_reg;
                end
            endcase
        end
    end

    // Timeout counter: cleared at grant, counts stalled ENABLE cycles.
    always_ff @(posedge PCLK or negedge PRST) begin
        if (!PRST) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == IDLE) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == BUSY && tmo_stall && !tmo_hit) begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_CNT_W'(1);
        end
    end

    // Response registers: rdata/err hold until the next transfer finishes.
    always_ff @(posedge PCLK or negedge PRST) begin
        if (!PRST) begin
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else if (state_reg == BUSY) begin
            if (apb_complete) begin
                if (cmd_rd_wr_reg) begin
                    rdata_reg <= apb_rd_data_out;
                end
                err_reg <= PSLVERR;
            end else if (PSLVERR || tmo_hit) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign gnt         = gnt_reg;
    assign err         = err_reg;
    assign rdata       = rdata_reg;
    assign RD_WR       = cmd_rd_wr_reg;
    assign apb_rd_padd = cmd_addr_reg;
    assign apb_wr_padd = cmd_addr_reg;
    assign apb_wr_data = cmd_wdata_reg;

endmodule
